alu_flag_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_flag_unit_core.sv | 69 ++++++
 rtl/alu_flag_unit.sv | 192 +++++++++++++++++++
 tb/tb_alu_flag_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the execute-stage ALU: ARM
//               data-processing opcodes, NZCV flag bit indices, flag-enable
//               masks, FSM state encoding and an opcode classification helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ARM data-processing opcodes
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Flag write-enable masks
  localparam logic [3:0] FEN_ALL = 4'b1111;
  localparam logic [3:0] FEN_NZ  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // TST/TEQ/CMP/CMN: update flags unconditionally, never write the result
  function automatic logic is_test_op(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_flag_unit_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational ARM data-processing datapath. Produces
//               the result, carry and overflow, and reports whether the
//               opcode is arithmetic (C/V meaningful) or logical.
// Ports       : op     - 4-bit opcode
//               a, b   - operands Rn and Op2
//               cin    - incoming C flag (ADC/SBC/RSC)
//               result - operation result
//               c, v   - carry (NOT borrow on subtract) and signed overflow
//               arith  - 1 = arithmetic class, 0 = logical class
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             v,
  output logic             arith
);

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_ci;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH:0]   w_sum;

  // Subtraction is x + ~y + ci, so the adder carry-out is directly NOT borrow.
  always_comb begin
    w_x     = a;
    w_y     = b;
    w_ci    = 1'b0;
    w_logic = '0;
    arith   = 1'b0;
    case (op)
      OP_AND, OP_TST: w_logic = a & b;
      OP_EOR, OP_TEQ: w_logic = a ^ b;
      OP_ORR:         w_logic = a | b;
      OP_MOV:         w_logic = b;
      OP_BIC:         w_logic = a & ~b;
      OP_MVN:         w_logic = ~b;
      OP_SUB, OP_CMP: begin arith = 1'b1; w_y = ~b; w_ci = 1'b1; end
      OP_RSB:         begin arith = 1'b1; w_x = b; w_y = ~a; w_ci = 1'b1; end
      OP_ADD, OP_CMN: begin arith = 1'b1; end
      OP_ADC:         begin arith = 1'b1; w_ci = cin; end
      OP_SBC:         begin arith = 1'b1; w_y = ~b; w_ci = cin; end
      OP_RSC:         begin arith = 1'b1; w_x = b; w_y = ~a; w_ci = cin; end
      default:        w_logic = '0;
    endcase
  end

  assign w_sum  = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_ci};
  assign result = arith ? w_sum[WIDTH-1:0] : w_logic;
  assign c      = arith & w_sum[WIDTH];
  // Overflow: adder inputs share a sign and the sum's sign differs. For
  // subtraction y is already inverted, so this covers differing-sign operands.
  assign v      = arith & (w_x[WIDTH-1] == w_y[WIDTH-1])
                        & (w_sum[WIDTH-1] != w_x[WIDTH-1]);

endmodule
`default_nettype wire

// File: rtl/alu_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_flag_unit
// Description : Execute-stage ALU with NZCV flag-update generation.
//               Single-cycle data-processing ops plus an iterative shift-add
//               multiply (WIDTH cycles) behind a START/BUSY/DONE handshake.
// Ports       : clk      - rising-edge clock
//               rst      - synchronous active-low reset
//               start    - launch operation (ignored while busy)
//               op       - data-processing opcode
//               mul_sel  - 1 = multiply, op ignored
//               s        - set-flags bit
//               a, b     - operands Rn and Op2
//               carry_in - current C flag
//               busy     - multiply in progress
//               done     - one-cycle pulse, result/flags valid
//               result   - operation result (held until next done)
//               res_we   - register writeback enable
//               flag_d   - {N,Z,C,V} data (held until next done)
//               flag_en  - per-flag write enables
// Revision    : 1.0 - initial release
// ============================================================================
module alu_flag_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             mul_sel,
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             res_we,
  output logic [3:0]       flag_d,
  output logic [3:0]       flag_en
);

  localparam int               c_cnt_w     = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;

  logic [3:0]         r_op;
  logic               r_s;
  logic               r_mul_sel;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_cin;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_prod;
  logic [c_cnt_w-1:0] r_cnt;

  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic               r_res_we;
  logic [3:0]         r_flag_d;
  logic [3:0]         r_flag_en;

  logic [WIDTH-1:0]   w_core_res;
  logic               w_core_c;
  logic               w_core_v;
  logic               w_core_arith;

  logic [WIDTH-1:0]   w_res;
  logic [3:0]         w_flags;
  logic [3:0]         w_fen;
  logic               w_we;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op     (r_op),
    .a      (r_a),
    .b      (r_b),
    .cin    (r_cin),
    .result (w_core_res),
    .c      (w_core_c),
    .v      (w_core_v),
    .arith  (w_core_arith)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = mul_sel ? ST_MUL : ST_DONE;
        end else begin
          w_next   = ST_IDLE;
        end
      end
      ST_MUL:  if (r_cnt == c_last_iter) w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------- result / flag select
  always_comb begin
    w_flags = 4'b0000;
    if (r_mul_sel) begin
      w_res = r_prod;
      w_fen = r_s ? FEN_NZ : 4'b0000;
      w_we  = 1'b1;
    end else begin
      w_res = w_core_res;
      // Test ops always update flags; arithmetic class decides NZ vs NZCV.
      w_fen = (r_s || is_test_op(r_op)) ? (w_core_arith ? FEN_ALL : FEN_NZ)
                                        : 4'b0000;
      w_we  = !is_test_op(r_op);
    end
    w_flags[FLAG_N] = w_res[WIDTH-1];
    w_flags[FLAG_Z] = (w_res == '0);
    w_flags[FLAG_C] = w_core_c;
    w_flags[FLAG_V] = w_core_v;
  end

  // --------------------------------------------- operands / multiply / outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op      <= '0;
      r_s       <= 1'b0;
      r_mul_sel <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_cin     <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_prod    <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_res_we  <= 1'b0;
      r_flag_d  <= 4'b0000;
      r_flag_en <= 4'b0000;
    end else begin
      if (w_accept) begin
        r_op      <= op;
        r_s       <= s;
        r_mul_sel <= mul_sel;
        r_a       <= a;
        r_b       <= b;
        r_cin     <= carry_in;
        r_mcand   <= a;
        r_mplier  <= b;
        r_prod    <= '0;
        r_cnt     <= '0;
      end else if (r_state == ST_MUL) begin
        if (r_mplier[0]) r_prod <= r_prod + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end

      // Outputs are registered from the DONE state, so they appear one
      // cycle after the state is entered.
      r_done    <= (r_state == ST_DONE);
      r_res_we  <= (r_state == ST_DONE) && w_we;
      r_flag_en <= (r_state == ST_DONE) ? w_fen : 4'b0000;
      if (r_state == ST_DONE) begin
        r_result <= w_res;
        r_flag_d <= w_flags & w_fen;
      end
    end
  end

  assign busy    = (r_state == ST_MUL);
  assign done    = r_done;
  assign result  = r_result;
  assign res_we  = r_res_we;
  assign flag_d  = r_flag_d;
  assign flag_en = r_flag_en;

endmodule
`default_nettype wire

// File: tb/tb_alu_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_flag_unit
// Description : Directed self-checking bench for alu_flag_unit (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_flag_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic        mul_sel;
  logic        s;
  logic [31:0] a;
  logic [31:0] b;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        res_we;
  logic [3:0]  flag_d;
  logic [3:0]  flag_en;

  int n_vec  = 0;
  int n_fail = 0;

  alu_flag_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .mul_sel  (mul_sel),
    .s        (s),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .res_we   (res_we),
    .flag_d   (flag_d),
    .flag_en  (flag_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one single-cycle op, accept it, then leave the DUT one edge
  // before DONE so the caller can check the done cycle after one tick.
  task automatic issue(input logic [3:0] o, input logic sf, input logic [31:0] av,
                       input logic [31:0] bv, input logic ci);
    op = o; s = sf; a = av; b = bv; carry_in = ci; mul_sel = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; carry_in = ~ci;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;

    rst = 1'b0; start = 1'b1; op = 4'b0100; mul_sel = 1'b0; s = 1'b1;
    a = 32'h1; b = 32'h1; carry_in = 1'b0;

    // ---------------- reset and hold
    tick();
    check("rst1_done", {31'b0, done}, 32'h0);
    tick();
    check("rst_busy",    {31'b0, busy}, 32'h0);
    check("rst_done",    {31'b0, done}, 32'h0);
    check("rst_result",  result, 32'h0);
    check("rst_res_we",  {31'b0, res_we}, 32'h0);
    check("rst_flag_d",  {28'b0, flag_d}, 32'h0);
    check("rst_flag_en", {28'b0, flag_en}, 32'h0);
    rst = 1'b1; start = 1'b0;
    tick();
    check("idle_done", {31'b0, done}, 32'h0);
    check("idle_busy", {31'b0, busy}, 32'h0);

    // ---------------- ADD 0x7FFFFFFF + 1, S=1
    issue(4'b0100, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0);
    check("add_early_done", {31'b0, done}, 32'h0);
    tick();
    check("add_done",    {31'b0, done}, 32'h1);
    check("add_result",  result, 32'h8000_0000);
    check("add_flag_d",  {28'b0, flag_d}, 32'b1001);
    check("add_flag_en", {28'b0, flag_en}, 32'b1111);
    check("add_res_we",  {31'b0, res_we}, 32'h1);
    tick();
    check("add_post_done",   {31'b0, done}, 32'h0);
    check("add_post_en",     {28'b0, flag_en}, 32'h0);
    check("add_post_we",     {31'b0, res_we}, 32'h0);
    check("add_hold_result", result, 32'h8000_0000);
    check("add_hold_flag_d", {28'b0, flag_d}, 32'b1001);

    // ---------------- CMP 5,5 with S=0
    issue(4'b1010, 1'b0, 32'd5, 32'd5, 1'b0);
    tick();
    check("cmp_done",    {31'b0, done}, 32'h1);
    check("cmp_result",  result, 32'h0);
    check("cmp_flag_d",  {28'b0, flag_d}, 32'b0110);
    check("cmp_flag_en", {28'b0, flag_en}, 32'b1111);
    check("cmp_res_we",  {31'b0, res_we}, 32'h0);
    tick();

    // ---------------- SUB 3-5, S=1: borrow gives C=0, negative result
    issue(4'b0010, 1'b1, 32'd3, 32'd5, 1'b1);
    tick();
    check("sub_result",  result, 32'hFFFF_FFFE);
    check("sub_flag_d",  {28'b0, flag_d}, 32'b1000);
    check("sub_flag_en", {28'b0, flag_en}, 32'b1111);
    tick();

    // ---------------- TST S=0: NZ only, no writeback
    issue(4'b1000, 1'b0, 32'h0000_00F0, 32'h0000_000F, 1'b1);
    tick();
    check("tst_result",  result, 32'h0);
    check("tst_flag_d",  {28'b0, flag_d}, 32'b0100);
    check("tst_flag_en", {28'b0, flag_en}, 32'b1100);
    check("tst_res_we",  {31'b0, res_we}, 32'h0);
    tick();

    // ---------------- ORR then ADC back-to-back (START held in DONE)
    op = 4'b1100; s = 1'b1; a = 32'h0; b = 32'h0; carry_in = 1'b1; start = 1'b1;
    tick();
    op = 4'b0101; s = 1'b0; a = 32'd1; b = 32'd2; carry_in = 1'b1;
    tick();
    check("orr_done",    {31'b0, done}, 32'h1);
    check("orr_result",  result, 32'h0);
    check("orr_flag_d",  {28'b0, flag_d}, 32'b0100);
    check("orr_flag_en", {28'b0, flag_en}, 32'b1100);
    check("orr_res_we",  {31'b0, res_we}, 32'h1);
    start = 1'b0; carry_in = 1'b0;
    tick();
    check("adc_done",    {31'b0, done}, 32'h1);
    check("adc_result",  result, 32'd4);
    check("adc_flag_en", {28'b0, flag_en}, 32'b0000);
    check("adc_flag_d",  {28'b0, flag_d}, 32'b0000);
    check("adc_res_we",  {31'b0, res_we}, 32'h1);
    tick();
    check("adc_post_done", {31'b0, done}, 32'h0);

    // ---------------- MUL 0xFFFFFFFF * 3, S=1, with ignored STARTs
    mul_sel = 1'b1; s = 1'b1; a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; a = 32'h0; b = 32'h0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      busy_cnt++;
      if (done) done_cnt++;
      if (i == 5) begin start = 1'b1; mul_sel = 1'b0; op = 4'b0100; a = 32'd9; b = 32'd9; end
      if (i == 8) start = 1'b0;
      tick();
    end
    check("mul_busy_cycles", busy_cnt, 32'd32);
    check("mul_done_in_busy", done_cnt, 32'd0);
    tick();
    check("mul_done",    {31'b0, done}, 32'h1);
    check("mul_result",  result, 32'hFFFF_FFFD);
    check("mul_flag_d",  {28'b0, flag_d}, 32'b1000);
    check("mul_flag_en", {28'b0, flag_en}, 32'b1100);
    check("mul_res_we",  {31'b0, res_we}, 32'h1);
    tick();
    check("mul_post_done", {31'b0, done}, 32'h0);
    check("mul_post_busy", {31'b0, busy}, 32'h0);

    // ---------------- reset mid-MUL
    mul_sel = 1'b1; s = 1'b1; a = 32'd7; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy_before", {31'b0, busy}, 32'h1);
    rst = 1'b0;
    tick();
    check("mid_busy",    {31'b0, busy}, 32'h0);
    check("mid_done",    {31'b0, done}, 32'h0);
    check("mid_result",  result, 32'h0);
    check("mid_flag_d",  {28'b0, flag_d}, 32'h0);
    check("mid_flag_en", {28'b0, flag_en}, 32'h0);
    check("mid_res_we",  {31'b0, res_we}, 32'h0);
    rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    check("mid_no_done", done_cnt, 32'd0);

    issue(4'b0100, 1'b0, 32'd2, 32'd3, 1'b0);
    tick();
    check("post_add_done",   {31'b0, done}, 32'h1);
    check("post_add_result", result, 32'd5);
    check("post_add_en",     {28'b0, flag_en}, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
